// File: rtl/pipe_ctrl_pkg.sv
// Shared defines and types for the pipeline hazard controller.
// Holds the GPR address range macro and the controller state encoding.
// Compiled ahead of every other file that uses these names.
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define GPR_ADDR_SPACE 4:0
`endif

package pipe_ctrl_pkg;

  // Encoding 3 is never produced; next-state logic falls back to RUN.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EX_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam int GPR_ADDR_W = 5;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Load-use detector: the instruction in ID reads a register a load in EXE writes.
// Latency: purely combinational.
// Backpressure: none; the result feeds the stall/flush priority logic.
module hazard_cmp
  import pipe_ctrl_pkg::*;
(
  input  logic [`GPR_ADDR_SPACE] rs1_addr,
  input  logic [`GPR_ADDR_SPACE] rs2_addr,
  input  logic                   rs1_re,
  input  logic                   rs2_re,
  input  logic [`GPR_ADDR_SPACE] rd_addr,
  input  logic                   rd_we,
  input  logic                   mem_re,
  output logic                   load_use
);

  logic rs1_hit;
  logic rs2_hit;
  logic rd_live;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign rd_live  = mem_re & rd_we & (rd_addr != '0);
  assign rs1_hit  = rs1_re & (rs1_addr == rd_addr);
  assign rs2_hit  = rs2_re & (rs2_addr == rd_addr);
  assign load_use = rd_live & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with saturating stall and branch-flush counters.
// Latency: stall/flush outputs are combinational from the current inputs; state/counters update next edge.
// Backpressure: memory wait holds the whole front end; multi-cycle EXE holds up to ID/EXE.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [`GPR_ADDR_SPACE] id_rs1_addr_i,
  input  logic [`GPR_ADDR_SPACE] id_rs2_addr_i,
  input  logic                   id_rs1_re_i,
  input  logic                   id_rs2_re_i,
  input  logic [`GPR_ADDR_SPACE] ex_rd_addr_i,
  input  logic                   ex_rd_we_i,
  input  logic                   ex_mem_re_i,
  input  logic                   ex_multi_i,
  input  logic                   ex_done_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ready_i,
  input  logic                   br_taken_i,
  output logic                   pc_stall_o,
  output logic                   if_id_stall_o,
  output logic                   id_exe_stall_o,
  output logic                   exe_mem_stall_o,
  output logic                   if_id_flush_o,
  output logic                   id_exe_flush_o,
  output logic                   exe_mem_flush_o,
  output logic                   mem_wb_flush_o,
  output logic [1:0]             state_o,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [CNT_W-1:0]       flush_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  state_t           state_d;
  logic             mem_hold;
  logic             ex_hold;
  logic             load_use;
  logic             br_flush;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  assign mem_hold = mem_req_i & ~mem_ready_i;
  // A multi-cycle op finishing this cycle does not hold anything.
  assign ex_hold  = ex_multi_i & ~ex_done_i;

  hazard_cmp u_hazard_cmp (
    .rs1_addr (id_rs1_addr_i),
    .rs2_addr (id_rs2_addr_i),
    .rs1_re   (id_rs1_re_i),
    .rs2_re   (id_rs2_re_i),
    .rd_addr  (ex_rd_addr_i),
    .rd_we    (ex_rd_we_i),
    .mem_re   (ex_mem_re_i),
    .load_use (load_use)
  );

  // State register; reset wins over any hold in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Priority resolution: mem_hold > ex_hold > branch > load_use. A branch masked by a
  // hold stays asserted (EXE is frozen) and is flushed once the hold releases.
  always_comb begin
    pc_stall_o      = 1'b0;
    if_id_stall_o   = 1'b0;
    id_exe_stall_o  = 1'b0;
    exe_mem_stall_o = 1'b0;
    if_id_flush_o   = 1'b0;
    id_exe_flush_o  = 1'b0;
    exe_mem_flush_o = 1'b0;
    mem_wb_flush_o  = 1'b0;
    br_flush        = 1'b0;
    state_d         = RUN;
    if (rst_i) begin
      // Every pipeline register loads a bubble while reset is held.
      if_id_flush_o   = 1'b1;
      id_exe_flush_o  = 1'b1;
      exe_mem_flush_o = 1'b1;
      mem_wb_flush_o  = 1'b1;
    end else if (mem_hold) begin
      pc_stall_o      = 1'b1;
      if_id_stall_o   = 1'b1;
      id_exe_stall_o  = 1'b1;
      exe_mem_stall_o = 1'b1;
      mem_wb_flush_o  = 1'b1;
      state_d         = MEM_WAIT;
    end else if (ex_hold) begin
      pc_stall_o      = 1'b1;
      if_id_stall_o   = 1'b1;
      id_exe_stall_o  = 1'b1;
      exe_mem_flush_o = 1'b1;
      state_d         = EX_BUSY;
    end else if (br_taken_i) begin
      if_id_flush_o   = 1'b1;
      id_exe_flush_o  = 1'b1;
      br_flush        = 1'b1;
    end else if (load_use) begin
      pc_stall_o      = 1'b1;
      if_id_stall_o   = 1'b1;
      id_exe_flush_o  = 1'b1;
    end
  end

  // Saturating performance counters: stalled cycles and branch flushes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall_o && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (br_flush && flush_cnt_q != CNT_MAX)   flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver pushes model predictions, monitor pops and compares.
// Two instances share stimulus: default counter width and a 4-bit one for saturation.
// Directed hazard scenarios followed by randomized traffic.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [GPR_ADDR_W-1:0] rs1, rs2, rd;
  logic                  rs1_re, rs2_re, rd_we, mem_re;
  logic                  ex_multi, ex_done, mem_req, mem_ready, br;

  logic        pc_st, ifid_st, idex_st, exmem_st;
  logic        ifid_fl, idex_fl, exmem_fl, memwb_fl;
  logic [1:0]  state;
  logic [15:0] scnt, fcnt;

  logic        pc_st4, ifid_st4, idex_st4, exmem_st4;
  logic        ifid_fl4, idex_fl4, exmem_fl4, memwb_fl4;
  logic [1:0]  state4;
  logic [3:0]  scnt4, fcnt4;

  pipe_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_re_i(rs1_re), .id_rs2_re_i(rs2_re),
    .ex_rd_addr_i(rd), .ex_rd_we_i(rd_we), .ex_mem_re_i(mem_re),
    .ex_multi_i(ex_multi), .ex_done_i(ex_done), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .br_taken_i(br),
    .pc_stall_o(pc_st), .if_id_stall_o(ifid_st), .id_exe_stall_o(idex_st), .exe_mem_stall_o(exmem_st),
    .if_id_flush_o(ifid_fl), .id_exe_flush_o(idex_fl), .exe_mem_flush_o(exmem_fl), .mem_wb_flush_o(memwb_fl),
    .state_o(state), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_re_i(rs1_re), .id_rs2_re_i(rs2_re),
    .ex_rd_addr_i(rd), .ex_rd_we_i(rd_we), .ex_mem_re_i(mem_re),
    .ex_multi_i(ex_multi), .ex_done_i(ex_done), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .br_taken_i(br),
    .pc_stall_o(pc_st4), .if_id_stall_o(ifid_st4), .id_exe_stall_o(idex_st4), .exe_mem_stall_o(exmem_st4),
    .if_id_flush_o(ifid_fl4), .id_exe_flush_o(idex_fl4), .exe_mem_flush_o(exmem_fl4), .mem_wb_flush_o(memwb_fl4),
    .state_o(state4), .stall_cnt_o(scnt4), .flush_cnt_o(fcnt4)
  );

  typedef struct {
    logic [3:0] stall;   // {exe_mem, id_exe, if_id, pc}
    logic [3:0] flush;   // {mem_wb, exe_mem, id_exe, if_id}
    int         st;
    int         scnt;
    int         fcnt;
    int         scnt4;
    int         fcnt4;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: values the DUT registers hold after the last edge.
  int m_state, m_scnt, m_fcnt, m_scnt4, m_fcnt4;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Classify the cycle by the highest-priority cause, then look up its effect.
  task automatic step();
    exp_t e;
    bit   hold_m, hold_x, lu, br_eff;
    hold_m = mem_req && !mem_ready;
    hold_x = ex_multi && !ex_done;
    lu     = mem_re && rd_we && (rd != 0) &&
             ((rs1_re && rs1 == rd) || (rs2_re && rs2 == rd));
    br_eff = 0;
    e.st = m_state; e.scnt = m_scnt; e.fcnt = m_fcnt; e.scnt4 = m_scnt4; e.fcnt4 = m_fcnt4;
    if (rst)         begin e.stall = 4'b0000; e.flush = 4'b1111; end
    else if (hold_m) begin e.stall = 4'b1111; e.flush = 4'b1000; end
    else if (hold_x) begin e.stall = 4'b0111; e.flush = 4'b0100; end
    else if (br)     begin e.stall = 4'b0000; e.flush = 4'b0011; br_eff = 1; end
    else if (lu)     begin e.stall = 4'b0011; e.flush = 4'b0010; end
    else             begin e.stall = 4'b0000; e.flush = 4'b0000; end
    q.push_back(e);
    if (rst) begin
      m_state = 0; m_scnt = 0; m_fcnt = 0; m_scnt4 = 0; m_fcnt4 = 0;
    end else begin
      m_state = hold_m ? 2 : (hold_x ? 1 : 0);
      if (e.stall[0]) begin
        if (m_scnt < 65535) m_scnt++;
        if (m_scnt4 < 15)   m_scnt4++;
      end
      if (br_eff) begin
        if (m_fcnt < 65535) m_fcnt++;
        if (m_fcnt4 < 15)   m_fcnt4++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; rs1 = 0; rs2 = 0; rd = 0; rs1_re = 0; rs2_re = 0; rd_we = 0; mem_re = 0;
    ex_multi = 0; ex_done = 0; mem_req = 0; mem_ready = 0; br = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; step(); rst = 0;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_vec", int'({exmem_st, idex_st, ifid_st, pc_st}), int'(e.stall));
        chk("flush_vec", int'({memwb_fl, exmem_fl, idex_fl, ifid_fl}), int'(e.flush));
        chk("state", int'(state), e.st);
        chk("stall_cnt", int'(scnt), e.scnt);
        chk("flush_cnt", int'(fcnt), e.fcnt);
        chk("stall_cnt_w4", int'(scnt4), e.scnt4);
        chk("flush_cnt_w4", int'(fcnt4), e.fcnt4);
        chk("stall_flush_overlap",
            int'({exmem_st, idex_st, ifid_st} & {exmem_fl, idex_fl, ifid_fl}), 0);
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    m_state = 0; m_scnt = 0; m_fcnt = 0; m_scnt4 = 0; m_fcnt4 = 0;
    step();

    // Load-use on rs2: one stall cycle with one bubble.
    do_reset();
    mem_re = 1; rd_we = 1; rd = 5; rs2 = 5; rs2_re = 1; rs1 = 3; rs1_re = 1;
    step();
    idle(); step();
    chk("lu_stall_cnt", int'(scnt), 1);

    // Load targeting x0 never stalls.
    mem_re = 1; rd_we = 1; rd = 0; rs1 = 0; rs1_re = 1;
    step();
    idle();

    // Multi-cycle EXE op: four held cycles then completion.
    do_reset();
    ex_multi = 1;
    repeat (4) step();
    chk("exbusy_state", int'(state), 1);
    ex_done = 1; step();
    idle(); step();
    chk("exbusy_stall_cnt", int'(scnt), 4);
    chk("exbusy_state_after", int'(state), 0);

    // Memory wait masking a taken branch; branch flushes once memory is ready.
    do_reset();
    mem_req = 1; br = 1;
    repeat (3) step();
    mem_ready = 1; step();
    chk("br_after_wait_flush_cnt", int'(fcnt), 1);
    idle(); step();

    // Long stall saturates the narrow counter.
    do_reset();
    mem_req = 1;
    repeat (20) step();
    chk("sat_stall_cnt_w4", int'(scnt4), 15);
    chk("sat_stall_cnt_w16", int'(scnt), 20);

    // Reset in the middle of a multi-cycle hold.
    idle(); ex_multi = 1;
    repeat (2) step();
    rst = 1; step();
    chk("rst_mid_state", int'(state), 0);
    chk("rst_mid_stall_cnt", int'(scnt), 0);
    step();
    idle(); step();

    // Randomized traffic with small register indices to provoke dependencies.
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      rs1       = GPR_ADDR_W'($urandom_range(0, 3));
      rs2       = GPR_ADDR_W'($urandom_range(0, 3));
      rd        = GPR_ADDR_W'($urandom_range(0, 3));
      rs1_re    = 1'($urandom);
      rs2_re    = 1'($urandom);
      rd_we     = 1'($urandom);
      mem_re    = 1'($urandom);
      ex_multi  = ($urandom_range(0, 3) == 0);
      ex_done   = 1'($urandom);
      mem_req   = ($urandom_range(0, 3) == 0);
      mem_ready = 1'($urandom);
      br        = ($urandom_range(0, 5) == 0);
      step();
    end
    idle();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 SHALL have ports clk_i in 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i in 1, reset, synchronous and active-high.
REQ-004 SHALL have ports id_rs1_addr_i, id_rs2_addr_i in `GPR_ADDR_SPACE, the source registers of the instruction in ID.
REQ-005 SHALL have ports id_rs1_re_i, id_rs2_re_i in 1, the source-read enables of the instruction in ID.
REQ-006 SHALL have ports ex_rd_addr_i in `GPR_ADDR_SPACE, ex_rd_we_i in 1 and ex_mem_re_i in 1, driven from the ID/EXE register outputs.
REQ-007 SHALL have ports ex_multi_i in 1 (EXE holds a multi-cycle op) and ex_done_i in 1 (multi-cycle result valid this cycle).
REQ-008 SHALL have ports mem_req_i in 1 (MEM stage accessing data memory) and mem_ready_i in 1 (memory completes this cycle).
REQ-009 SHALL have port br_taken_i in 1, a taken branch or jump resolved in EXE.
REQ-010 SHALL have outputs pc_stall_o, if_id_stall_o, id_exe_stall_o, exe_mem_stall_o, each out 1, holding the named register.
REQ-011 SHALL have outputs if_id_flush_o, id_exe_flush_o, exe_mem_flush_o, mem_wb_flush_o, each out 1, loading a bubble (all write/read enables 0).
REQ-012 SHALL have outputs state_o out 2, stall_cnt_o out CNT_W and flush_cnt_o out CNT_W.

Function
REQ-013 SHALL implement states RUN=0, EX_BUSY=1, MEM_WAIT=2, encoded in state_o; encoding 3 unused and treated as RUN.
REQ-014 SHALL define mem_hold = mem_req_i & !mem_ready_i; ex_hold = ex_multi_i & !ex_done_i; load_use = ex_mem_re_i & ex_rd_we_i & ex_rd_addr_i!=0 & ((id_rs1_re_i & id_rs1_addr_i==ex_rd_addr_i) | (id_rs2_re_i & id_rs2_addr_i==ex_rd_addr_i)).
REQ-015 SHALL resolve conditions in fixed priority mem_hold > ex_hold > br_taken_i > load_use, with outputs combinational from the current inputs.
REQ-016 mem_hold SHALL assert pc, if_id, id_exe and exe_mem stalls plus mem_wb_flush_o, and no other flush.
REQ-017 ex_hold without mem_hold SHALL assert pc, if_id and id_exe stalls plus exe_mem_flush_o.
REQ-018 br_taken_i alone SHALL assert if_id_flush_o and id_exe_flush_o with no stalls, so exactly two bubbles follow the branch.
REQ-019 load_use alone SHALL assert pc and if_id stalls plus id_exe_flush_o, inserting exactly one bubble; no other flush is asserted.
REQ-020 SHALL never assert a stall and a flush on the same pipeline register in one cycle.
REQ-021 Next-state logic SHALL be: mem_hold -> MEM_WAIT; else ex_hold -> EX_BUSY; else RUN.
REQ-022 A branch masked by a higher-priority hold SHALL produce its flush in the first cycle the hold releases, because EXE is held and br_taken_i stays asserted.
REQ-023 ex_multi_i with ex_done_i high in the same cycle SHALL cause no stall and no state change.
REQ-024 stall_cnt_o SHALL increment by 1 every cycle pc_stall_o=1 and saturate at all-ones.
REQ-025 flush_cnt_o SHALL increment once per cycle REQ-018 applies and saturate at all-ones.

Reset
REQ-026 While rst_i=1 at a clock edge, state SHALL become RUN and both counters 0, overriding any hold in progress.
REQ-027 While rst_i=1, all stall outputs SHALL be 0 and all flush outputs SHALL be 1, so every pipeline register loads a bubble.

Structure
REQ-028 State encodings and `GPR_ADDR_SPACE SHALL reside in the shared defines header.
REQ-029 The load-use comparator SHALL be one sub-module, hazard_cmp, instantiated once.

Verification
REQ-030 Check load-use: ex_mem_re=1, ex_rd_we=1, ex_rd=5, id_rs2=5, rs2_re=1 -> pc/if_id stall=1 and id_exe_flush=1 for one cycle; stall_cnt=1.
REQ-031 Check rd=0 with a matching rs1 (rd=0, rs1=0) -> no stall and no flush.
REQ-032 Check ex_multi=1 and ex_done=0 held for 4 cycles, then done=1 -> state_o=1 during the hold, 4 stall cycles, exe_mem_flush each stall cycle, state RUN after.
REQ-033 Check mem_req=1 and ready=0 for 3 cycles with br_taken=1 -> MEM_WAIT, no if_id flush until ready=1; in that cycle, if_id_flush=1, id_exe_flush=1 and flush_cnt=1.
REQ-034 Check CNT_W=4 with a 20-cycle stall -> stall_cnt_o saturates at 15.
REQ-035 Check rst_i asserted mid-EX_BUSY -> next cycle state_o=0, counters 0, and all flushes=1 while reset is held.
